// File: rtl/div_pkg.sv
// Shared constants, types and line-layout helpers for the batch divider sequencer.
package div_pkg;

    localparam int DATA_LEN       = 32;
    localparam int PIPELINE_STAGE = 16;
    localparam int LANES          = 8;
    localparam int CL_BITS        = 512;

    localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W     = $clog2(LANES + 1);
    localparam int USED_BITS = LANES * DATA_LEN + LANES;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COLLECT,
        OUTPUT
    } t_div_state;

    typedef struct packed {
        logic              valid;
        logic [LANE_W-1:0] lane;
        logic              zero;
    } t_div_tag;

    // Input line: lane i holds a at 2*DATA_LEN*i and b right above it.
    function automatic int a_off(input int lane);
        return 2 * DATA_LEN * lane;
    endfunction

    function automatic int b_off(input int lane);
        return 2 * DATA_LEN * lane + DATA_LEN;
    endfunction

    // Result line: packed quotients, then one divide-by-zero flag per lane.
    function automatic int q_off(input int lane);
        return DATA_LEN * lane;
    endfunction

    function automatic int flag_off();
        return LANES * DATA_LEN;
    endfunction

endpackage

// File: rtl/div_tag_delay.sv
// Fixed-depth shift register of lane tags that tracks results travelling through the divider.
module div_tag_delay
    import div_pkg::*;
#(
    parameter int DEPTH = PIPELINE_STAGE
) (
    input  logic     clk,
    input  logic     srst_i,
    input  logic     clear_i,
    input  t_div_tag tag_i,
    output t_div_tag tag_o
);

    t_div_tag stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (srst_i || clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/div_batch_sequencer.sv
// Accepts one line of operand pairs, issues a pair per cycle to the pipelined divider,
// and reassembles the returning quotients (with divide-by-zero flags) into one result line.
module div_batch_sequencer
    import div_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CL_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CL_BITS-1:0]  out_data,
    output logic [DATA_LEN-1:0] div_a,
    output logic [DATA_LEN-1:0] div_b,
    input  logic [DATA_LEN-1:0] div_result,
    output logic                busy,
    output logic [31:0]         lines_done
);

    t_div_state          state_q;
    logic [CL_BITS-1:0]  line_q;
    logic [LANE_W-1:0]   lane_q;
    logic [CNT_W-1:0]    collect_q;
    logic [CNT_W-1:0]    collect_d;
    logic [DATA_LEN-1:0] div_a_q;
    logic [DATA_LEN-1:0] div_b_q;
    t_div_tag            push_tag_q;
    t_div_tag            ret_tag;
    logic [DATA_LEN-1:0] slot_q [LANES];
    logic [DATA_LEN-1:0] slot_d [LANES];
    logic [LANES-1:0]    flags_q;
    logic [LANES-1:0]    flags_d;
    logic [CL_BITS-1:0]  out_data_q;
    logic                out_valid_q;
    logic                in_ready_q;
    logic [31:0]         lines_done_q;

    logic [DATA_LEN-1:0] op_a [LANES];
    logic [DATA_LEN-1:0] op_b [LANES];
    logic [DATA_LEN-1:0] lane_a;
    logic [DATA_LEN-1:0] lane_b;
    logic [CL_BITS-1:0]  result_line;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_unpack
        assign op_a[gi] = line_q[a_off(gi) +: DATA_LEN];
        assign op_b[gi] = line_q[b_off(gi) +: DATA_LEN];
    end

    assign lane_a = op_a[lane_q];
    assign lane_b = op_b[lane_q];

    // The tag register sits beside div_a/div_b, so the delay line lines up with div_result.
    div_tag_delay #(
        .DEPTH(PIPELINE_STAGE)
    ) u_tag_delay (
        .clk     (clk),
        .srst_i  (reset),
        .clear_i (clear),
        .tag_i   (push_tag_q),
        .tag_o   (ret_tag)
    );

    // Zero-divisor lanes take all-ones regardless of what the divider produced.
    always_comb begin
        slot_d    = slot_q;
        flags_d   = flags_q;
        collect_d = collect_q;
        if (ret_tag.valid) begin
            slot_d[ret_tag.lane]  = ret_tag.zero ? '1 : div_result;
            flags_d[ret_tag.lane] = ret_tag.zero;
            collect_d             = collect_q + 1'b1;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_pack
        assign result_line[q_off(gi) +: DATA_LEN] = slot_d[gi];
    end
    assign result_line[flag_off() +: LANES] = flags_d;
    if (USED_BITS < CL_BITS) begin : g_pad
        assign result_line[CL_BITS-1:USED_BITS] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q     <= IDLE;
            line_q      <= '0;
            lane_q      <= '0;
            collect_q   <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            push_tag_q  <= '0;
            flags_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
                slot_q[i] <= '0;
            end
            if (reset) begin
                lines_done_q <= '0;
            end
        end else begin
            div_a_q    <= '0;
            div_b_q    <= '0;
            push_tag_q <= '0;
            slot_q     <= slot_d;
            flags_q    <= flags_d;
            collect_q  <= collect_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        line_q     <= in_data;
                        lane_q     <= '0;
                        collect_q  <= '0;
                        flags_q    <= '0;
                        in_ready_q <= 1'b0;
                        for (int i = 0; i < LANES; i++) begin
                            slot_q[i] <= '0;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    div_a_q          <= lane_a;
                    div_b_q          <= lane_b;
                    push_tag_q.valid <= 1'b1;
                    push_tag_q.lane  <= lane_q;
                    push_tag_q.zero  <= (lane_b == '0);
                    if (lane_q == LANE_W'(LANES - 1)) begin
                        state_q <= COLLECT;
                    end else begin
                        lane_q <= lane_q + 1'b1;
                    end
                end
                COLLECT: begin
                    if (collect_d == CNT_W'(LANES)) begin
                        out_data_q  <= result_line;
                        out_valid_q <= 1'b1;
                        state_q     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q  <= 1'b0;
                        in_ready_q   <= 1'b1;
                        lines_done_q <= lines_done_q + 32'd1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;
    assign busy       = (state_q != IDLE);
    assign lines_done = lines_done_q;

endmodule
